// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller: turns load/store requests into a
// req/ack memory transaction, stalls the pipeline meanwhile, flags errors.
module dmem_access_ctrl #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] ALUdata_i,
  input  logic [DATA_W-1:0] MemWdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] MemRdata_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              req_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic access;
  logic aligned;
  logic is_load;
  logic last_cyc;

  assign access   = MemRead_i | MemWrite_i;
  assign aligned  = (ALUdata_i[1:0] == 2'b00);
  assign is_load  = MemRead_i & ~MemWrite_i;
  assign last_cyc = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // DONE keeps stall low so EX/MEM advances past the finished instruction
  assign stall_o = ((state_q == IDLE) & access) | (state_q == BUSY);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (access) begin
            if (MemRead_i & MemWrite_i) begin
              err_q <= 1'b1;
            end
            if (aligned) begin
              req_q   <= 1'b1;
              we_q    <= MemWrite_i;
              addr_q  <= ALUdata_i;
              wdata_q <= MemWdata_i;
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              err_q <= 1'b1;
              if (is_load) begin
                rdata_q <= '0;
              end
              state_q <= DONE;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_ack_i) begin
            req_q <= 1'b0;
            if (!we_q) begin
              rdata_q <= mem_rdata_i;
            end
            state_q <= DONE;
          end else if (last_cyc) begin
            req_q <= 1'b0;
            err_q <= 1'b1;
            if (!we_q) begin
              rdata_q <= '0;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign MemRdata_o  = rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus randomized
// instruction streams checked against a per-instruction reference model.
module tb_dmem_access_ctrl;

  localparam int T = 16;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ALUdata;
  logic [31:0] MemWdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] MemRdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  // observations returned by the instruction driver
  int          o_stalls;
  int          o_busy;
  int          o_hold_bad;
  logic        o_we;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic        o_req_done;
  logic [31:0] o_rdat;
  logic        o_err;

  // reference model state
  logic [31:0] m_rdat;
  logic        m_err;

  dmem_access_ctrl #(
    .DATA_W(32),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .MemRead_i(MemRead),
    .MemWrite_i(MemWrite),
    .ALUdata_i(ALUdata),
    .MemWdata_i(MemWdata),
    .mem_req_o(mem_req),
    .mem_we_o(mem_we),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata),
    .stall_o(stall),
    .MemRdata_o(MemRdata),
    .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one instruction until the pipeline advances past it; the
  // memory acks on busy cycle ack_at (0 = never).
  task automatic run_instr(
    input logic        rd,
    input logic        wr,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] rdata,
    input int          ack_at,
    input bit          ack_done
  );
    bit fin;
    fin        = 1'b0;
    o_stalls   = 0;
    o_busy     = 0;
    o_hold_bad = 0;
    o_we       = 1'bx;
    o_addr     = 'x;
    o_wdata    = 'x;
    o_req_done = 1'bx;
    o_rdat     = 'x;
    o_err      = 1'bx;
    MemRead    = rd;
    MemWrite   = wr;
    ALUdata    = addr;
    MemWdata   = wdata;
    mem_ack    = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      #1;
      if (mem_req) begin
        o_busy++;
        if (o_busy == 1) begin
          o_we    = mem_we;
          o_addr  = mem_addr;
          o_wdata = mem_wdata;
        end else if ({mem_we, mem_addr, mem_wdata} !== {o_we, o_addr, o_wdata}) begin
          o_hold_bad++;
        end
        if (o_busy == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
      end
      if (stall) begin
        o_stalls++;
      end else begin
        fin        = 1'b1;
        o_req_done = mem_req;
        o_rdat     = MemRdata;
        o_err      = err;
        if (ack_done) mem_ack = 1'b1;
      end
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Spec-level outcome of one instruction: stall count, busy cycles, and
  // updated load-data / sticky-error state.
  function automatic void model(
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] rdata,
    input  int          ack_at,
    output int          e_stalls,
    output int          e_busy
  );
    bit hit;
    bit ld;
    ld = rd && !wr;
    if (addr % 4 != 0) begin
      e_stalls = 1;
      e_busy   = 0;
      m_err    = 1'b1;
      if (ld) m_rdat = 32'h0;
    end else begin
      hit      = (ack_at >= 1) && (ack_at <= T);
      e_busy   = hit ? ack_at : T;
      e_stalls = 1 + e_busy;
      if (!hit || (rd && wr)) m_err = 1'b1;
      if (ld) m_rdat = hit ? rdata : 32'h0;
    end
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUdata  = '0;
    MemWdata = '0;
    mem_ack  = 1'b0;
    mem_rdata = '0;
    #2;
    total++;
    if ({mem_req, stall, err, MemRdata} !== 35'h0) begin
      bad++;
      $display("FAIL reset_outs got=%b_%b_%b_%h want=0", mem_req, stall, err, MemRdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({mem_req, stall, err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_hold got=%b%b%b want=000", mem_req, stall, err);
    end
    @(negedge clk);
  endtask

  task automatic test_load();
    run_instr(1, 0, 32'h100, 32'h0, 32'hCAFEF00D, 2, 0);
    total++;
    if (o_stalls !== 3) begin
      bad++;
      $display("FAIL load_stall got=%0d want=3", o_stalls);
    end
    total++;
    if (o_rdat !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL load_data got=%h want=cafef00d", o_rdat);
    end
    total++;
    if ({o_we, o_addr} !== {1'b0, 32'h100}) begin
      bad++;
      $display("FAIL load_req got=%b_%h want=0_00000100", o_we, o_addr);
    end
    total++;
    if (o_err !== 1'b0) begin
      bad++;
      $display("FAIL load_err got=%b want=0", o_err);
    end
  endtask

  task automatic test_store();
    run_instr(0, 1, 32'h204, 32'h12345678, 32'hDEADBEEF, 1, 0);
    total++;
    if (o_stalls !== 2) begin
      bad++;
      $display("FAIL store_stall got=%0d want=2", o_stalls);
    end
    total++;
    if ({o_we, o_addr, o_wdata} !== {1'b1, 32'h204, 32'h12345678}) begin
      bad++;
      $display("FAIL store_req got=%b_%h_%h want=1_00000204_12345678",
               o_we, o_addr, o_wdata);
    end
    total++;
    if (o_rdat !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL store_rdata got=%h want=cafef00d", o_rdat);
    end
  endtask

  task automatic test_timeout_ack_last();
    run_instr(1, 0, 32'h300, 32'h0, 32'hA5A55A5A, T, 0);
    total++;
    if (o_stalls !== T + 1 || o_busy !== T) begin
      bad++;
      $display("FAIL ack_last_len got=%0d/%0d want=%0d/%0d", o_stalls, o_busy, T + 1, T);
    end
    total++;
    if ({o_err, o_rdat} !== {1'b0, 32'hA5A55A5A}) begin
      bad++;
      $display("FAIL ack_last_data got=%b_%h want=0_a5a55a5a", o_err, o_rdat);
    end
    total++;
    if (o_hold_bad !== 0) begin
      bad++;
      $display("FAIL ack_last_hold got=%0d want=0", o_hold_bad);
    end
  endtask

  task automatic test_misaligned();
    run_instr(1, 0, 32'h102, 32'h0, 32'h0, 1, 0);
    total++;
    if (o_stalls !== 1 || o_busy !== 0) begin
      bad++;
      $display("FAIL misalign_len got=%0d/%0d want=1/0", o_stalls, o_busy);
    end
    total++;
    if ({o_err, o_rdat} !== {1'b1, 32'h0}) begin
      bad++;
      $display("FAIL misalign_out got=%b_%h want=1_00000000", o_err, o_rdat);
    end
    run_instr(1, 0, 32'h108, 32'h0, 32'h0BADF00D, 1, 0);
    total++;
    if ({o_err, o_rdat} !== {1'b1, 32'h0BADF00D}) begin
      bad++;
      $display("FAIL err_sticky got=%b_%h want=1_0badf00d", o_err, o_rdat);
    end
  endtask

  task automatic test_timeout();
    run_instr(1, 0, 32'h400, 32'h0, 32'h0, 0, 0);
    total++;
    if (o_stalls !== T + 1 || o_busy !== T) begin
      bad++;
      $display("FAIL timeout_len got=%0d/%0d want=%0d/%0d", o_stalls, o_busy, T + 1, T);
    end
    total++;
    if ({o_req_done, o_err, o_rdat} !== {2'b01, 32'h0}) begin
      bad++;
      $display("FAIL timeout_out got=%b_%b_%h want=0_1_00000000",
               o_req_done, o_err, o_rdat);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    mem_ack = 1'b1;
    #1;
    total++;
    if ({mem_req, stall} !== 2'b00) begin
      bad++;
      $display("FAIL spurious_idle got=%b%b want=00", mem_req, stall);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL spurious_issue got=%b want=0", mem_req);
    end
    @(negedge clk);
    run_instr(1, 0, 32'h10, 32'h0, 32'h11111111, 1, 1);
    total++;
    if (o_busy !== 1 || o_req_done !== 1'b0 || o_rdat !== 32'h11111111) begin
      bad++;
      $display("FAIL b2b_ld0 got=%0d_%b_%h want=1_0_11111111", o_busy, o_req_done, o_rdat);
    end
    run_instr(0, 1, 32'h20, 32'h55AA55AA, 32'h0, 2, 1);
    total++;
    if (o_busy !== 2 || {o_we, o_addr, o_wdata} !== {1'b1, 32'h20, 32'h55AA55AA}) begin
      bad++;
      $display("FAIL b2b_st got=%0d_%b_%h_%h want=2_1_00000020_55aa55aa",
               o_busy, o_we, o_addr, o_wdata);
    end
    run_instr(1, 0, 32'h30, 32'h0, 32'h33333333, 3, 0);
    total++;
    if (o_busy !== 3 || o_rdat !== 32'h33333333 || o_err !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ld1 got=%0d_%h_%b want=3_33333333_0", o_busy, o_rdat, o_err);
    end
  endtask

  task automatic test_random();
    int          e_stalls;
    int          e_busy;
    int          r;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
    apply_reset();
    m_rdat = 32'h0;
    m_err  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      addr  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) < 2) addr[1:0] = 2'($urandom_range(1, 3));
      wdata = $urandom;
      rdata = $urandom;
      r = $urandom_range(0, 9);
      ack_at = (r == 0) ? 0 : (r == 1) ? T : (r == 2) ? T + 1 : $urandom_range(1, 4);
      model(rd, wr, addr, rdata, ack_at, e_stalls, e_busy);
      run_instr(rd, wr, addr, wdata, rdata, ack_at, $urandom_range(0, 1) == 1);
      total++;
      if (o_stalls !== e_stalls || o_busy !== e_busy) begin
        bad++;
        $display("FAIL rnd%0d_len got=%0d/%0d want=%0d/%0d",
                 i, o_stalls, o_busy, e_stalls, e_busy);
      end
      total++;
      if (o_rdat !== m_rdat || o_err !== m_err || o_req_done !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d_out got=%h_%b_%b want=%h_%b_0",
                 i, o_rdat, o_err, o_req_done, m_rdat, m_err);
      end
      if (e_busy > 0) begin
        total++;
        if ({o_we, o_addr, o_wdata} !== {wr, addr, wdata} || o_hold_bad !== 0) begin
          bad++;
          $display("FAIL rnd%0d_req got=%b_%h_%h_%0d want=%b_%h_%h_0",
                   i, o_we, o_addr, o_wdata, o_hold_bad, wr, addr, wdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    bit got;
    run_instr(1, 0, 32'h40, 32'h0, 32'h77665544, 1, 0);
    run_instr(0, 1, 32'h41, 32'h0, 32'h0, 1, 0);
    total++;
    if ({o_err, o_rdat} !== {1'b1, 32'h77665544}) begin
      bad++;
      $display("FAIL pre_reset got=%b_%h want=1_77665544", o_err, o_rdat);
    end
    MemRead = 1'b1;
    ALUdata = 32'h500;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_req) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL midbusy_req got=0 want=1");
    end
    rst     = 1'b1;
    MemRead = 1'b0;
    #1;
    total++;
    if ({mem_req, stall, err, MemRdata} !== 35'h0) begin
      bad++;
      $display("FAIL midbusy_reset got=%b_%b_%b_%h want=0", mem_req, stall, err, MemRdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout_ack_last();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
